read_hazard_ctrl: RTL and testbench
===================================

# read_hazard_ctrl

Issue controller for the read stage of the in-order core pipeline. Holds one instruction bundle between decode and execute and tracks pending register writes in a busy-bit scoreboard. Releases the instruction downstream only when none of its source or destination registers has a write outstanding. Handles pipeline flush and counts hazard-stall cycles for performance monitoring.

## Interface
Parameters:
- ADDR_WIDTH, 30: word address width of the bundle (byte address is {addr, 2'b00}).
- INSN_WIDTH, 32: instruction word width.
- NUM_REGS, 32: architectural integer registers; register 0 is hardwired zero.
- REG_IDX_W, 5: register index width, equal to clog2(NUM_REGS).

Ports (clock and reset first):
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-low.
- in_valid  in  1  decode offers a bundle.
- in_ready  out  1  block accepts the offered bundle this cycle.
- in_addr  in  ADDR_WIDTH  bundle word address.
- in_insn  in  INSN_WIDTH  instruction word.
- in_rs1, in_rs2  in  REG_IDX_W each  source register indices.
- in_rs1_en, in_rs2_en  in  1 each  source register is read.
- in_rd  in  REG_IDX_W  destination register index.
- in_rd_en  in  1  instruction writes rd.
- out_valid  out  1  held bundle is hazard-free and offered to execute.
- out_ready  in  1  execute accepts the bundle.
- out_addr, out_insn, out_rd, out_rd_en  out  matching widths  held bundle fields.
- wb_valid  in  1  writeback retires a register write.
- wb_rd  in  REG_IDX_W  register being written back.
- flush  in  1  pipeline redirect; kills the held bundle and all issued, unretired writes.
- stalled  out  1  held bundle is blocked by a hazard.
- stall_cnt  out  16  saturating count of hazard-stall cycles.

## Operation
- State machine with two states.
  - EMPTY: no bundle held.
  - HELD: one bundle registered.
  - EMPTY→HELD on accept without issue.
  - HELD→EMPTY on issue with no new accept.
  - HELD→HELD on issue plus same-cycle accept (back-to-back).
- Scoreboard: busy[NUM_REGS-1:0]. busy[0] is always 0.
- Effective busy = busy & ~(wb_valid ? onehot(wb_rd) : 0). A writeback in the same cycle bypasses the hazard.
- hazard = (rs1_en & eff_busy[rs1]) | (rs2_en & eff_busy[rs2]) | (rd_en & eff_busy[rd]). The rd term covers WAW.
- out_valid = HELD & ~hazard & ~flush. stalled = HELD & hazard & ~flush.
- Issue = out_valid & out_ready. On issue, set busy[rd] if rd_en and rd != 0.
- Writeback clears busy[wb_rd]. If issue sets and writeback clears the same rd in one cycle, the set wins.
- in_ready = ~flush & (EMPTY | issue). Accept = in_valid & in_ready; the bundle is captured into the held registers.
- flush has highest priority:
  - next state EMPTY;
  - all busy bits cleared;
  - in_valid, out_ready and wb_valid in that cycle are ignored.
- Pipeline contract: after a flush, no killed instruction raises wb_valid.
- stall_cnt increments on each cycle with stalled = 1 and saturates at 0xFFFF. It is cleared only by reset.

## Timing
- Reset (rst = 0 at a clock edge) sets:
  - state EMPTY, busy all 0, stall_cnt 0;
  - out_addr, out_insn, out_rd 0 and out_rd_en 0;
  - out_valid 0, stalled 0;
  - in_ready 1 from the first cycle after reset deasserts.
- Reset in mid-operation discards the held bundle and the scoreboard exactly as flush does.
- Latency: a bundle accepted at edge N is offered (out_valid = 1) in cycle N+1 if it has no hazard.
- Throughput: one bundle per cycle with continuous out_ready and no hazards.
- Writeback visibility: a wb in cycle C unblocks a dependent held bundle in the same cycle C (combinational bypass). busy reflects the clear from C+1.
- Handshake rules:
  - out_addr, out_insn, out_rd and out_rd_en stay stable while HELD and not issued.
  - in_* fields are sampled only on accept.
  - out_valid may drop without an issue only due to flush.

## Test plan
- Back-to-back independent stream: 4 bundles, rd=1..4, sources x0, out_ready=1 → out_valid high 4 consecutive cycles, busy=0x1E, stall_cnt=0.
- RAW stall: issue rd=5, then a bundle with rs1=5; wb_rd=5 three cycles later → stalled=1 for 2 cycles, issue in the wb cycle, stall_cnt=2.
- Same-cycle set/clear: wb_rd=7 in the same cycle that a bundle with rd=7 issues → busy[7]=1 afterwards, a following rs2=7 bundle stalls.
- Flush while stalled with busy=0x00F0 and in_valid=1 → next cycle EMPTY, busy=0, in_ready=1, the offered bundle is not captured.
- Register zero and downstream backpressure: rd=0 issue leaves busy=0; out_ready=0 for 3 cycles holds out_insn stable, in_ready=0, stall_cnt unchanged.
- Saturation and reset: force 70000 stall cycles → stall_cnt=0xFFFF; then rst=0 for one edge → all outputs at their reset values.

Source files
------------

// File: rtl/read_hazard_ctrl.sv
// read_hazard_ctrl: read-stage issue slot with busy-bit scoreboard, flush and stall counter
module read_hazard_ctrl #(
    parameter int ADDR_WIDTH = 30,
    parameter int INSN_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int REG_IDX_W  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [INSN_WIDTH-1:0] in_insn,
    input  logic [REG_IDX_W-1:0]  in_rs1,
    input  logic [REG_IDX_W-1:0]  in_rs2,
    input  logic                  in_rs1_en,
    input  logic                  in_rs2_en,
    input  logic [REG_IDX_W-1:0]  in_rd,
    input  logic                  in_rd_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [INSN_WIDTH-1:0] out_insn,
    output logic [REG_IDX_W-1:0]  out_rd,
    output logic                  out_rd_en,
    input  logic                  wb_valid,
    input  logic [REG_IDX_W-1:0]  wb_rd,
    input  logic                  flush,
    output logic                  stalled,
    output logic [15:0]           stall_cnt
);
    typedef enum logic {EMPTY, HELD} state_t;
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [INSN_WIDTH-1:0] insn;
        logic [REG_IDX_W-1:0]  rs1;
        logic [REG_IDX_W-1:0]  rs2;
        logic [REG_IDX_W-1:0]  rd;
        logic                  rs1_en;
        logic                  rs2_en;
        logic                  rd_en;
    } bundle_t;
    localparam logic [NUM_REGS-1:0] ONE = {{(NUM_REGS-1){1'b0}}, 1'b1};
    state_t              state_q, state_d;
    bundle_t             bun_q, bun_d;
    logic [NUM_REGS-1:0] busy_q, busy_d, wb_mask, eff_busy, set_mask;
    logic [15:0]         stall_q, stall_d;
    logic                held, hazard, issue, accept;
    assign out_addr  = bun_q.addr;
    assign out_insn  = bun_q.insn;
    assign out_rd    = bun_q.rd;
    assign out_rd_en = bun_q.rd_en;
    assign stall_cnt = stall_q;
    // hazard check against the scoreboard with same-cycle writeback bypass, handshakes
    always_comb begin
        held      = state_q == HELD;
        wb_mask   = wb_valid ? ONE << wb_rd : '0;
        eff_busy  = busy_q & ~wb_mask;
        hazard    = (bun_q.rs1_en & eff_busy[bun_q.rs1]) | (bun_q.rs2_en & eff_busy[bun_q.rs2])
                  | (bun_q.rd_en & eff_busy[bun_q.rd]);
        out_valid = held & ~hazard & ~flush;
        stalled   = held & hazard & ~flush;
        issue     = out_valid & out_ready;
        in_ready  = ~flush & (~held | issue);
        accept    = in_valid & in_ready;
        set_mask  = (issue && bun_q.rd_en && bun_q.rd != '0) ? ONE << bun_q.rd : '0;
        busy_d    = flush ? '0 : (busy_q & ~wb_mask) | set_mask;
        busy_d[0] = 1'b0;
        stall_d   = (stalled && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
        bun_d     = accept ? '{addr: in_addr, insn: in_insn, rs1: in_rs1, rs2: in_rs2, rd: in_rd,
                               rs1_en: in_rs1_en, rs2_en: in_rs2_en, rd_en: in_rd_en} : bun_q;
    end
    // slot occupancy: flush empties, accept fills, issue alone drains
    always_comb begin
        state_d = flush ? EMPTY : accept ? HELD : issue ? EMPTY : state_q;
    end
    // state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= EMPTY;
            bun_q   <= '0;
            busy_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            bun_q   <= bun_d;
            busy_q  <= busy_d;
            stall_q <= stall_d;
        end
    end
endmodule

// File: tb/tb_read_hazard_ctrl.sv
// tb_read_hazard_ctrl: directed checks of issue, hazards, bypass, flush, backpressure, saturation, reset
module tb_read_hazard_ctrl;
    logic        clk = 1'b0, rst = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [29:0] in_addr = '0;
    logic [31:0] in_insn = '0;
    logic [4:0]  in_rs1 = '0, in_rs2 = '0, in_rd = '0;
    logic        in_rs1_en = 1'b0, in_rs2_en = 1'b0, in_rd_en = 1'b0;
    logic        out_valid, out_ready = 1'b0;
    logic [29:0] out_addr;
    logic [31:0] out_insn;
    logic [4:0]  out_rd;
    logic        out_rd_en;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic        flush = 1'b0, stalled;
    logic [15:0] stall_cnt;
    int total = 0, bad = 0;

    read_hazard_ctrl dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
        .in_insn(in_insn), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs1_en(in_rs1_en),
        .in_rs2_en(in_rs2_en), .in_rd(in_rd), .in_rd_en(in_rd_en), .out_valid(out_valid),
        .out_ready(out_ready), .out_addr(out_addr), .out_insn(out_insn), .out_rd(out_rd),
        .out_rd_en(out_rd_en), .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
        .stalled(stalled), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic offer(input logic [29:0] a, input logic [31:0] i, input logic [4:0] r1,
                         input logic e1, input logic [4:0] r2, input logic e2,
                         input logic [4:0] d, input logic de);
        in_valid = 1'b1; in_addr = a; in_insn = i;
        in_rs1 = r1; in_rs1_en = e1; in_rs2 = r2; in_rs2_en = e2; in_rd = d; in_rd_en = de;
    endtask

    initial begin
        tick(); tick();
        settle();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_stalled", 32'(stalled), 32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_out_addr", 32'(out_addr), 32'd0);
        chk("rst_out_insn", out_insn, 32'd0);
        chk("rst_out_rd", {26'd0, out_rd_en, out_rd}, 32'd0);
        rst = 1'b1;
        tick(); settle();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // back-to-back independent stream rd=1..4, sources x0
        out_ready = 1'b1;
        offer(30'h101, 32'hA000_0001, 5'd0, 1'b1, 5'd0, 1'b1, 5'd1, 1'b1);
        tick();
        for (int k = 1; k <= 4; k++) begin
            if (k < 4) offer(30'(30'h100 + k + 1), 32'hA000_0000 + 32'(k + 1), 5'd0, 1'b1, 5'd0, 1'b1, 5'(k + 1), 1'b1);
            else in_valid = 1'b0;
            settle();
            chk("stream_valid", 32'(out_valid), 32'd1);
            chk("stream_rd", 32'(out_rd), 32'(k));
            chk("stream_addr", 32'(out_addr), 32'h100 + 32'(k));
            chk("stream_in_ready", 32'(in_ready), 32'd1);
            tick();
        end
        settle();
        chk("stream_empty", 32'(out_valid), 32'd0);
        chk("stream_stall_cnt", 32'(stall_cnt), 32'd0);

        // busy[1] set by the stream: dependent bundle stalls, wb bypass releases it
        offer(30'h200, 32'hB000_0000, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        tick(); in_valid = 1'b0; settle();
        chk("b1_stalled", 32'(stalled), 32'd1);
        chk("b1_valid", 32'(out_valid), 32'd0);
        chk("b1_in_ready", 32'(in_ready), 32'd0);
        tick(); wb_valid = 1'b1; wb_rd = 5'd1; settle();
        chk("b1_bypass_valid", 32'(out_valid), 32'd1);
        chk("b1_bypass_stalled", 32'(stalled), 32'd0);
        tick(); wb_valid = 1'b0;
        flush = 1'b1;
        offer(30'h222, 32'hDEAD_0000, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        settle();
        chk("flush1_in_ready", 32'(in_ready), 32'd0);
        tick(); flush = 1'b0; in_valid = 1'b0; settle();
        chk("flush1_empty", 32'(out_valid), 32'd0);
        chk("flush1_in_ready_after", 32'(in_ready), 32'd1);
        chk("flush1_stall_cnt", 32'(stall_cnt), 32'd1);

        // RAW: rd=5 issues, rs1=5 bundle stalls 2 cycles, wb in the third releases it
        offer(30'h300, 32'hC000_0005, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
        tick();
        offer(30'h301, 32'hC000_0006, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        settle();
        chk("raw_producer_valid", 32'(out_valid), 32'd1);
        tick(); in_valid = 1'b0; settle();
        chk("raw_stall_c1", 32'(stalled), 32'd1);
        tick(); settle();
        chk("raw_stall_c2", 32'(stalled), 32'd1);
        tick(); wb_valid = 1'b1; wb_rd = 5'd5; settle();
        chk("raw_wb_issue", 32'(out_valid), 32'd1);
        chk("raw_wb_insn", out_insn, 32'hC000_0006);
        tick(); wb_valid = 1'b0; settle();
        chk("raw_stall_cnt", 32'(stall_cnt), 32'd3);

        // same-cycle set/clear on rd=7: set wins
        offer(30'h400, 32'hD000_0007, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
        tick();
        offer(30'h401, 32'hD000_0008, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
        tick(); in_valid = 1'b0; settle();
        chk("waw_stall", 32'(stalled), 32'd1);
        tick(); wb_valid = 1'b1; wb_rd = 5'd7;
        offer(30'h402, 32'hD000_0009, 5'd0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0);
        settle();
        chk("waw_bypass_issue", 32'(out_valid), 32'd1);
        tick(); wb_valid = 1'b0; in_valid = 1'b0; settle();
        chk("setwins_rs2_stall", 32'(stalled), 32'd1);
        tick(); wb_valid = 1'b1; wb_rd = 5'd7; settle();
        chk("setwins_release", 32'(out_valid), 32'd1);
        tick(); wb_valid = 1'b0; settle();
        chk("setwins_stall_cnt", 32'(stall_cnt), 32'd5);

        // flush while stalled with busy=0x00F0 and a bundle offered
        offer(30'h504, 32'hE000_0004, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1);
        tick();
        for (int k = 4; k <= 7; k++) begin
            if (k < 7) offer(30'(30'h500 + k + 1), 32'hE000_0000 + 32'(k + 1), 5'd0, 1'b0, 5'd0, 1'b0, 5'(k + 1), 1'b1);
            else offer(30'h5FF, 32'hE000_00FF, 5'd6, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
            tick();
        end
        in_valid = 1'b0; settle();
        chk("f2_stalled", 32'(stalled), 32'd1);
        tick(); flush = 1'b1;
        offer(30'h600, 32'hF000_0000, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        settle();
        chk("f2_flush_stalled", 32'(stalled), 32'd0);
        chk("f2_flush_valid", 32'(out_valid), 32'd0);
        tick(); flush = 1'b0; in_valid = 1'b0; settle();
        chk("f2_in_ready", 32'(in_ready), 32'd1);
        chk("f2_empty", 32'(out_valid), 32'd0);
        tick(); settle();
        chk("f2_not_captured", 32'(out_valid), 32'd0);
        chk("f2_stall_cnt", 32'(stall_cnt), 32'd6);

        // busy cleared by flush; rd=0 issue under backpressure
        offer(30'h700, 32'h7777_0000, 5'd4, 1'b1, 5'd7, 1'b1, 5'd0, 1'b1);
        tick();
        offer(30'h701, 32'h7777_0001, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_insn", out_insn, 32'h7777_0000);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_stall_cnt", 32'(stall_cnt), 32'd6);
            tick();
        end
        out_ready = 1'b1;
        tick(); in_valid = 1'b0; settle();
        chk("x0_not_busy", 32'(out_valid), 32'd1);
        chk("x0_insn", out_insn, 32'h7777_0001);

        // saturation: rd=9 issues, rs1=9 bundle stalls indefinitely
        offer(30'h800, 32'h9999_0000, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
        tick();
        offer(30'h801, 32'h9999_0001, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        tick(); in_valid = 1'b0;
        for (int k = 0; k < 65528; k++) tick();
        settle();
        chk("sat_minus1", 32'(stall_cnt), 32'hFFFE);
        for (int k = 0; k < 12; k++) tick();
        settle();
        chk("sat_value", 32'(stall_cnt), 32'hFFFF);
        chk("sat_still_stalled", 32'(stalled), 32'd1);

        // mid-operation reset
        rst = 1'b0;
        tick(); rst = 1'b1; settle();
        chk("rst2_valid", 32'(out_valid), 32'd0);
        chk("rst2_stalled", 32'(stalled), 32'd0);
        chk("rst2_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst2_fields", {out_addr[1:0], out_rd_en, out_rd} | 32'(out_addr) | out_insn, 32'd0);
        chk("rst2_in_ready", 32'(in_ready), 32'd1);
        offer(30'h900, 32'h9999_0002, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        tick(); in_valid = 1'b0; settle();
        chk("rst2_busy_cleared", 32'(out_valid), 32'd1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
